// File: rtl/regfile_cmd_ctrl.sv
// Command front-end for a 4-entry register file: sequences write/read commands
// onto the regfile pins and returns read data over a valid/ready response channel.
//   state   | meaning
//   S_IDLE  | ready for a command; regfile pins hold their last values
//   S_WRITE | single-cycle WE pulse; regfile commits at the closing edge
//   S_READ  | address held for RD_LAT+1 cycles until DOUT is captured
//   S_RESP  | response presented until the consumer accepts it
module regfile_cmd_ctrl #(
    parameter int AW     = 2,
    parameter int DW     = 4,
    parameter int RD_LAT = 1,
    parameter int CW     = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic          i_cmd_wr,
    input  logic [AW-1:0] i_cmd_addr,
    input  logic [DW-1:0] i_cmd_wdata,
    output logic          o_rsp_valid,
    input  logic          i_rsp_ready,
    output logic [AW-1:0] o_rsp_addr,
    output logic [DW-1:0] o_rsp_rdata,
    output logic [AW-1:0] o_rf_addr,
    output logic          o_rf_we,
    output logic [DW-1:0] o_rf_din,
    input  logic [DW-1:0] i_rf_dout,
    output logic          o_busy,
    output logic [CW-1:0] o_wr_cnt,
    output logic [CW-1:0] o_rd_cnt
);

    localparam int LW = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          r_cmd_ready;
    logic          r_busy;
    logic          r_rsp_valid;
    logic [AW-1:0] r_rsp_addr;
    logic [DW-1:0] r_rsp_rdata;
    logic [AW-1:0] r_rf_addr;
    logic          r_rf_we;
    logic [DW-1:0] r_rf_din;
    logic [CW-1:0] r_wr_cnt;
    logic [CW-1:0] r_rd_cnt;
    logic [LW-1:0] r_cnt;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                // ready is low for one cycle after reset, so acceptance needs it too
                w_accept = i_cmd_valid && r_cmd_ready;
                if (w_accept) begin
                    w_next = i_cmd_wr ? S_WRITE : S_READ;
                end
            end
            S_WRITE: w_next = S_IDLE;
            S_READ: begin
                if (r_cnt == '0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
            r_rf_addr   <= '0;
            r_rf_we     <= 1'b0;
            r_rf_din    <= '0;
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == S_IDLE);
            r_busy      <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rf_addr  <= i_cmd_addr;
                        r_rsp_addr <= i_cmd_addr;
                        if (i_cmd_wr) begin
                            r_rf_din <= i_cmd_wdata;
                            r_rf_we  <= 1'b1;
                        end else begin
                            r_cnt <= LW'(RD_LAT);
                        end
                    end
                end
                S_WRITE: begin
                    r_rf_we  <= 1'b0;
                    r_wr_cnt <= r_wr_cnt + 1'b1;
                end
                S_READ: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= i_rf_dout;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rd_cnt    <= r_rd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_busy      = r_busy;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_addr  = r_rsp_addr;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rf_addr   = r_rf_addr;
    assign o_rf_we     = r_rf_we;
    assign o_rf_din    = r_rf_din;
    assign o_wr_cnt    = r_wr_cnt;
    assign o_rd_cnt    = r_rd_cnt;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: three instances (RD_LAT 0, 1, 3), each with its own
// regfile model, checked against a transaction-level memory/counter model.
module tb_regfile_cmd_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       cmd_valid [3];
    logic       cmd_ready [3];
    logic       cmd_wr    [3];
    logic [1:0] cmd_addr  [3];
    logic [3:0] cmd_wdata [3];
    logic       rsp_valid [3];
    logic       rsp_ready [3];
    logic [1:0] rsp_addr  [3];
    logic [3:0] rsp_rdata [3];
    logic [1:0] rf_addr   [3];
    logic       rf_we     [3];
    logic [3:0] rf_din    [3];
    logic [3:0] rf_dout   [3];
    logic       busy      [3];
    logic [7:0] wr_cnt    [3];
    logic [7:0] rd_cnt    [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [3:0] mem  [4];
        logic [3:0] pipe [3];

        regfile_cmd_ctrl #(.AW(2), .DW(4), .RD_LAT(LAT), .CW(8)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_cmd_valid (cmd_valid[g]),
            .o_cmd_ready (cmd_ready[g]),
            .i_cmd_wr    (cmd_wr[g]),
            .i_cmd_addr  (cmd_addr[g]),
            .i_cmd_wdata (cmd_wdata[g]),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready[g]),
            .o_rsp_addr  (rsp_addr[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_rf_addr   (rf_addr[g]),
            .o_rf_we     (rf_we[g]),
            .o_rf_din    (rf_din[g]),
            .i_rf_dout   (rf_dout[g]),
            .o_busy      (busy[g]),
            .o_wr_cnt    (wr_cnt[g]),
            .o_rd_cnt    (rd_cnt[g])
        );

        // Regfile: write on WE, read data delayed by LAT register stages (none for LAT=0).
        always @(posedge clk) begin
            if (rf_we[g]) mem[rf_addr[g]] <= rf_din[g];
            pipe[0] <= mem[rf_addr[g]];
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign rf_dout[g] = (LAT == 0) ? mem[rf_addr[g]] : pipe[(LAT == 0) ? 0 : LAT - 1];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int       nvec = 0;
    int       nmis = 0;
    bit [3:0] mdl_mem [3][4];
    bit [7:0] exp_wr  [3];
    bit [7:0] exp_rd  [3];
    int       acc_cyc;
    int       prev_cyc;

    typedef struct {
        bit       wr;
        bit [1:0] addr;
        bit [3:0] wdata;
        bit [3:0] exp_rdata;
    } vec_t;
    vec_t tbl [6];

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s dut%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic chk_reset_state(input int k, input bit ready_exp);
        chk("rst_cmd_ready", k, 32'(cmd_ready[k]), 32'(ready_exp));
        chk("rst_busy",      k, 32'(busy[k]),      32'd0);
        chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 32'd0);
        chk("rst_rsp_addr",  k, 32'(rsp_addr[k]),  32'd0);
        chk("rst_rsp_rdata", k, 32'(rsp_rdata[k]), 32'd0);
        chk("rst_rf_addr",   k, 32'(rf_addr[k]),   32'd0);
        chk("rst_rf_we",     k, 32'(rf_we[k]),     32'd0);
        chk("rst_rf_din",    k, 32'(rf_din[k]),    32'd0);
        chk("rst_wr_cnt",    k, 32'(wr_cnt[k]),    32'd0);
        chk("rst_rd_cnt",    k, 32'(rd_cnt[k]),    32'd0);
    endtask

    // Waits for RSP_VALID after an acceptance edge; latency counted in edges.
    task automatic wait_rsp(input int k, input bit [1:0] a, input bit [3:0] d);
        int lat;
        lat = 0;
        while (rsp_valid[k] !== 1'b1 && lat < 10) begin
            chk("rf_addr_hold", k, 32'(rf_addr[k]), 32'(a));
            chk("we_in_read",   k, 32'(rf_we[k]),   32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("rsp_latency", k, 32'(lat),          32'(lat_of(k) + 1));
        chk("rsp_addr",    k, 32'(rsp_addr[k]),  32'(a));
        chk("rsp_rdata",   k, 32'(rsp_rdata[k]), 32'(d));
    endtask

    task automatic complete_rsp(input int k);
        @(posedge clk); #1;
        exp_rd[k]++;
        chk("rsp_drop", k, 32'({rsp_valid[k], cmd_ready[k], busy[k]}), 32'(3'b010));
        chk("rd_cnt",   k, 32'(rd_cnt[k]), 32'(exp_rd[k]));
    endtask

    task automatic send(input int k, input bit wr, input bit [1:0] a, input bit [3:0] d, input bit [3:0] exp_d);
        int n;
        n = 0;
        while (cmd_ready[k] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", k, 32'(n < 20), 32'd1);
        cmd_valid[k] = 1'b1;
        cmd_wr[k]    = wr;
        cmd_addr[k]  = a;
        cmd_wdata[k] = d;
        @(posedge clk); #1;
        cmd_valid[k] = 1'b0;
        acc_cyc = cyc;
        chk("accept_flags", k, 32'({cmd_ready[k], busy[k]}), 32'(2'b01));
        chk("rf_addr",      k, 32'(rf_addr[k]), 32'(a));
        if (wr) begin
            chk("we_pulse", k, 32'({rf_we[k], rf_din[k]}), 32'({1'b1, d}));
            @(posedge clk); #1;
            mdl_mem[k][a] = d;
            exp_wr[k]++;
            chk("we_end", k, 32'({rf_we[k], cmd_ready[k]}), 32'(2'b01));
            chk("wr_cnt", k, 32'(wr_cnt[k]), 32'(exp_wr[k]));
        end else begin
            wait_rsp(k, a, exp_d);
            if (rsp_ready[k]) complete_rsp(k);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            cmd_valid[k] = 1'b1;
            cmd_wr[k]    = 1'b1;
            cmd_addr[k]  = 2'd3;
            cmd_wdata[k] = 4'hF;
            rsp_ready[k] = 1'b1;
            exp_wr[k]    = 8'd0;
            exp_rd[k]    = 8'd0;
        end

        // Reset held with a pending write command: nothing may be accepted.
        repeat (5) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) chk_reset_state(k, 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_ready", k, 32'({cmd_ready[k], busy[k], rf_we[k]}), 32'(3'b100));
            cmd_valid[k] = 1'b0;
        end

        // Preload every entry, then reset: contents survive, counters clear.
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 4; a++)
                send(k, 1'b1, 2'(a), 4'(a + 8), 4'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_wr[k] = 8'd0;
            exp_rd[k] = 8'd0;
            chk_reset_state(k, 1'b0);
        end
        @(posedge clk); #1;

        tbl[0] = '{1'b1, 2'd0, 4'd1, 4'd0};
        tbl[1] = '{1'b1, 2'd1, 4'd2, 4'd0};
        tbl[2] = '{1'b1, 2'd2, 4'd3, 4'd0};
        tbl[3] = '{1'b0, 2'd0, 4'd0, 4'd1};
        tbl[4] = '{1'b0, 2'd1, 4'd0, 4'd2};
        tbl[5] = '{1'b0, 2'd2, 4'd0, 4'd3};
        prev_cyc = 0;
        for (int i = 0; i < 6; i++) begin
            send(1, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata);
            if (i > 0 && tbl[i].wr && tbl[i-1].wr)
                chk("write_spacing", 1, 32'(acc_cyc - prev_cyc), 32'd2);
            prev_cyc = acc_cyc;
        end
        chk("wr_cnt_3", 1, 32'(wr_cnt[1]), 32'd3);
        chk("rd_cnt_3", 1, 32'(rd_cnt[1]), 32'd3);

        // Backpressure: response held, a waiting command is only taken after release.
        rsp_ready[1] = 1'b0;
        cmd_valid[1] = 1'b1;
        cmd_wr[1]    = 1'b0;
        cmd_addr[1]  = 2'd1;
        @(posedge clk); #1;
        wait_rsp(1, 2'd1, 4'd2);
        cmd_addr[1] = 2'd2;
        repeat (6) begin
            @(posedge clk); #1;
            chk("bp_hold", 1, 32'({rsp_valid[1], rsp_rdata[1], rsp_addr[1], cmd_ready[1], busy[1]}),
                32'({1'b1, 4'd2, 2'd1, 1'b0, 1'b1}));
        end
        rsp_ready[1] = 1'b1;
        @(posedge clk); #1;
        exp_rd[1]++;
        chk("bp_release", 1, 32'({rsp_valid[1], cmd_ready[1], rf_addr[1]}), 32'({1'b0, 1'b1, 2'd1}));
        chk("bp_rd_cnt",  1, 32'(rd_cnt[1]), 32'(exp_rd[1]));
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        chk("bp_accept", 1, 32'({cmd_ready[1], rf_addr[1]}), 32'({1'b0, 2'd2}));
        wait_rsp(1, 2'd2, 4'd3);
        complete_rsp(1);

        // Read-after-write on every latency variant.
        for (int k = 0; k < 3; k++) begin
            send(k, 1'b1, 2'd3, 4'hA, 4'd0);
            send(k, 1'b0, 2'd3, 4'd0, 4'hA);
        end

        // Reset while a read is in flight.
        cmd_valid[1] = 1'b1;
        cmd_wr[1]    = 1'b0;
        cmd_addr[1]  = 2'd0;
        @(posedge clk); #1;
        cmd_valid[1] = 1'b0;
        chk("mid_read_busy", 1, 32'(busy[1]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_wr[k] = 8'd0;
            exp_rd[k] = 8'd0;
            chk_reset_state(k, 1'b0);
        end
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_rsp_after_rst", 1, 32'({rsp_valid[1], busy[1]}), 32'd0);
        end
        send(1, 1'b0, 2'd0, 4'd0, mdl_mem[1][0]);

        // Random traffic against the memory/counter model; dut1 runs long enough to wrap.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ((k == 1) ? 600 : 150); i++) begin
                bit       w;
                bit [1:0] a;
                bit [3:0] d;
                w = 1'($urandom_range(0, 1));
                a = 2'($urandom_range(0, 3));
                d = 4'($urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                send(k, w, a, d, mdl_mem[k][a]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
